operand_collect_stage: RTL and testbench

//  Registered, parametrised ALU operand-select stage for the vector pipeline.
//  - Resolves NUM_OPS source operands against NUM_FWD forwarding sources by register-address compare.
//  - Overrides op0 with PC and op1 with the immediate when requested.
//  - Registers the result behind a valid/ready handshake with a 2-entry skid buffer.
//  - Sits between decode/register-read and the ALU stage.

---
 rtl/operand_collect_stage.sv | 167 ++++++++++++++++
 tb/tb_operand_collect_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/operand_collect_stage.sv
// ALU operand-select stage: forward resolution, PC/immediate override, registered output with a skid entry.
// Optional FWD_COUNT_EN adds a saturating 16-bit count of forwarded operands on port fwd_count.
module operand_collect_stage #(
  parameter int OP_W    = 24,
  parameter int AW      = 4,
  parameter int NUM_OPS = 3,
  parameter int NUM_FWD = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_OPS*OP_W-1:0]   rd_data,
  input  logic [NUM_OPS*AW-1:0]     rs_addr,
  input  logic [OP_W-1:0]           imm,
  input  logic [OP_W-1:0]           pc,
  input  logic                      imm_src,
  input  logic                      branch_flag,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*AW-1:0]     fwd_addr,
  input  logic [NUM_FWD*OP_W-1:0]   fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_OPS*OP_W-1:0]   out_ops,
`ifdef FWD_COUNT_EN
  output logic [15:0]               fwd_count,
`endif
  output logic [NUM_OPS-1:0]        out_fwd_hit
);

  localparam int CW = $clog2(NUM_OPS + 1);

  function automatic logic [CW-1:0] popcount(input logic [NUM_OPS-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_OPS; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Stage p0: combinational operand selection on the incoming instruction
  logic [NUM_OPS*OP_W-1:0] sel_ops_p0;
  logic [NUM_OPS-1:0]      sel_hit_p0;

  always_comb begin
    sel_ops_p0 = '0;
    sel_hit_p0 = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      sel_ops_p0[k*OP_W +: OP_W] = rd_data[k*OP_W +: OP_W];
      // Scan oldest to youngest so the lowest matching index is applied last.
      for (int j = NUM_FWD - 1; j >= 0; j--) begin
        if (fwd_valid[j] && (fwd_addr[j*AW +: AW] == rs_addr[k*AW +: AW])) begin
          sel_ops_p0[k*OP_W +: OP_W] = fwd_data[j*OP_W +: OP_W];
          sel_hit_p0[k]              = 1'b1;
        end
      end
    end
    if (branch_flag) begin
      sel_ops_p0[0 +: OP_W] = pc;
      sel_hit_p0[0]         = 1'b0;
    end
    if (imm_src) begin
      sel_ops_p0[OP_W +: OP_W] = imm;
      sel_hit_p0[1]            = 1'b0;
    end
  end

  // Stage p1: main output register and skid entry
  logic                    main_vld_p1, skid_vld_p1, rdy_p1;
  logic [NUM_OPS*OP_W-1:0] main_ops_p1, skid_ops_p1;
  logic [NUM_OPS-1:0]      main_hit_p1, skid_hit_p1;

  logic cap, xfer;
  logic main_vld_nxt, skid_vld_nxt;
  logic main_ld_new, main_ld_skid, skid_ld;

  assign cap  = in_valid && rdy_p1;
  assign xfer = main_vld_p1 && out_ready;

  always_comb begin
    main_vld_nxt = main_vld_p1;
    skid_vld_nxt = skid_vld_p1;
    main_ld_new  = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    if (flush) begin
      main_vld_nxt = 1'b0;
      skid_vld_nxt = 1'b0;
    end else if (xfer) begin
      if (skid_vld_p1) begin
        main_ld_skid = 1'b1;
        skid_vld_nxt = cap;
        skid_ld      = cap;
      end else begin
        main_vld_nxt = cap;
        main_ld_new  = cap;
      end
    end else if (cap) begin
      if (!main_vld_p1) begin
        main_vld_nxt = 1'b1;
        main_ld_new  = 1'b1;
      end else begin
        skid_vld_nxt = 1'b1;
        skid_ld      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b0;
    end else begin
      main_vld_p1 <= main_vld_nxt;
      skid_vld_p1 <= skid_vld_nxt;
      rdy_p1      <= !skid_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_ops_p1 <= '0;
      main_hit_p1 <= '0;
      skid_ops_p1 <= '0;
      skid_hit_p1 <= '0;
    end else begin
      if (main_ld_new) begin
        main_ops_p1 <= sel_ops_p0;
        main_hit_p1 <= sel_hit_p0;
      end else if (main_ld_skid) begin
        main_ops_p1 <= skid_ops_p1;
        main_hit_p1 <= skid_hit_p1;
      end
      if (skid_ld) begin
        skid_ops_p1 <= sel_ops_p0;
        skid_hit_p1 <= sel_hit_p0;
      end
    end
  end

`ifdef FWD_COUNT_EN
  logic [15:0] cnt_p1;

  // Discarded flush-cycle captures are not counted.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_p1 <= '0;
    else if (cap && !flush)
      cnt_p1 <= sat_add16(cnt_p1, popcount(sel_hit_p0));
  end

  assign fwd_count = cnt_p1;
`endif

  assign in_ready    = rdy_p1;
  assign out_valid   = main_vld_p1;
  assign out_ops     = main_ops_p1;
  assign out_fwd_hit = main_hit_p1;

endmodule

// File: tb/tb_operand_collect_stage.sv
// Directed-vector bench for operand_collect_stage.
module tb_operand_collect_stage;

  logic        clk;
  logic        rst_n, flush, in_valid, out_ready, imm_src, branch_flag;
  logic        in_ready, out_valid;
  logic [71:0] rd_data, fwd_dummy, out_ops;
  logic [11:0] rs_addr;
  logic [23:0] imm, pc;
  logic [1:0]  fwd_valid;
  logic [7:0]  fwd_addr;
  logic [47:0] fwd_data;
  logic [2:0]  out_fwd_hit;
`ifdef FWD_COUNT_EN
  logic [15:0] fwd_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  operand_collect_stage #(.OP_W(24), .AW(4), .NUM_OPS(3), .NUM_FWD(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rd_data(rd_data), .rs_addr(rs_addr), .imm(imm), .pc(pc), .imm_src(imm_src),
    .branch_flag(branch_flag), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ops(out_ops),
`ifdef FWD_COUNT_EN
    .fwd_count(fwd_count),
`endif
    .out_fwd_hit(out_fwd_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; imm_src = 1'b0; branch_flag = 1'b0;
    rd_data = '0; rs_addr = {4'd3, 4'd2, 4'd1}; imm = '0; pc = '0;
    fwd_valid = 2'b00; fwd_addr = '0; fwd_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; idle_inputs();
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_ops !== 72'd0) begin n_fail++; $display("FAIL reset_out_ops: got %h expected 0", out_ops); end
    n_checks++; if (out_fwd_hit !== 3'b000) begin n_fail++; $display("FAIL reset_hit: got %b expected 000", out_fwd_hit); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_basic();
    idle_inputs(); out_ready = 1'b1;
    rd_data = {24'd30, 24'd20, 24'd10}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_ops !== {24'd30, 24'd20, 24'd10}) begin n_fail++; $display("FAIL basic_ops: got %h expected %h", out_ops, {24'd30, 24'd20, 24'd10}); end
    n_checks++; if (out_fwd_hit !== 3'b000) begin n_fail++; $display("FAIL basic_hit: got %b expected 000", out_fwd_hit); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_forwarding();
    idle_inputs(); out_ready = 1'b1;
    rd_data = {24'd30, 24'd20, 24'd10}; rs_addr = {4'd2, 4'd1, 4'd5};
    fwd_valid = 2'b11; fwd_addr = {4'd5, 4'd5}; fwd_data = {24'h111111, 24'hAAAAAA};
    in_valid = 1'b1;
    tick();
    n_checks++; if (out_ops !== {24'd30, 24'd20, 24'hAAAAAA}) begin n_fail++; $display("FAIL fwd_youngest_ops: got %h expected %h", out_ops, {24'd30, 24'd20, 24'hAAAAAA}); end
    n_checks++; if (out_fwd_hit !== 3'b001) begin n_fail++; $display("FAIL fwd_youngest_hit: got %b expected 001", out_fwd_hit); end
    // Only the older source valid; it also feeds operand 2 through a different address.
    fwd_valid = 2'b10; rs_addr = {4'd5, 4'd1, 4'd5};
    tick();
    n_checks++; if (out_ops !== {24'h111111, 24'd20, 24'h111111}) begin n_fail++; $display("FAIL fwd_older_ops: got %h expected %h", out_ops, {24'h111111, 24'd20, 24'h111111}); end
    n_checks++; if (out_fwd_hit !== 3'b101) begin n_fail++; $display("FAIL fwd_older_hit: got %b expected 101", out_fwd_hit); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_override();
    idle_inputs(); out_ready = 1'b1;
    rd_data = {24'd30, 24'd20, 24'd10}; rs_addr = {4'd2, 4'd5, 4'd5};
    fwd_valid = 2'b01; fwd_addr = {4'd0, 4'd5}; fwd_data = {24'h0, 24'hAAAAAA};
    branch_flag = 1'b1; pc = 24'h000100; imm_src = 1'b1; imm = 24'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_ops !== {24'd30, 24'd7, 24'h000100}) begin n_fail++; $display("FAIL override_ops: got %h expected %h", out_ops, {24'd30, 24'd7, 24'h000100}); end
    n_checks++; if (out_fwd_hit !== 3'b000) begin n_fail++; $display("FAIL override_hit: got %b expected 000", out_fwd_hit); end
    tick();
  endtask

  task automatic test_back_to_back();
    idle_inputs(); out_ready = 1'b0;
    rd_data = {24'd3, 24'd2, 24'd1}; in_valid = 1'b1;
    tick();
    rd_data = {24'd6, 24'd5, 24'd4};
    tick();
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_full_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_ops !== {24'd3, 24'd2, 24'd1}) begin n_fail++; $display("FAIL skid_head_ops: got %h expected %h", out_ops, {24'd3, 24'd2, 24'd1}); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_ops !== {24'd3, 24'd2, 24'd1}) begin n_fail++; $display("FAIL stall_hold: got %b/%h expected 1/%h", out_valid, out_ops, {24'd3, 24'd2, 24'd1}); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_ops !== {24'd6, 24'd5, 24'd4}) begin n_fail++; $display("FAIL drain_second: got %b/%h expected 1/%h", out_valid, out_ops, {24'd6, 24'd5, 24'd4}); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready: got %b expected 1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
    // Streaming: capture and transfer on the same edge.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_data = {24'(100 + i), 24'(200 + i), 24'(300 + i)};
      tick();
      n_checks++; if (out_ops !== {24'(100 + i), 24'(200 + i), 24'(300 + i)} || out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_%0d: got %b/%h expected 1/%h", i, out_valid, out_ops, {24'(100 + i), 24'(200 + i), 24'(300 + i)}); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    idle_inputs(); out_ready = 1'b0;
    rd_data = {24'd3, 24'd2, 24'd1}; in_valid = 1'b1;
    tick(); tick();
    flush = 1'b1; rd_data = {24'd9, 24'd9, 24'd9};
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_deliver: got %b expected 0", out_valid); end
    // Capture offered in the flush cycle with the stage empty is discarded.
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_capture_drop: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    idle_inputs(); out_ready = 1'b0;
    rd_data = {24'd3, 24'd2, 24'd1}; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0; rst_n = 1'b0; flush = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_ops !== 72'd0) begin n_fail++; $display("FAIL midreset_out: got %b/%h expected 0/0", out_valid, out_ops); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b expected 0", in_ready); end
    rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_release: got %b/%b expected 1/0", in_ready, out_valid); end
  endtask

`ifdef FWD_COUNT_EN
  task automatic test_fwd_count();
    n_checks++; if (fwd_count !== 16'd0) begin n_fail++; $display("FAIL count_reset: got %h expected 0", fwd_count); end
    idle_inputs(); out_ready = 1'b1;
    rs_addr = {4'd5, 4'd5, 4'd5}; fwd_valid = 2'b01; fwd_addr = {4'd0, 4'd5};
    in_valid = 1'b1;
    tick();
    n_checks++; if (fwd_count !== 16'd3) begin n_fail++; $display("FAIL count_one: got %0d expected 3", fwd_count); end
    for (int i = 1; i < 30000; i++) tick();
    in_valid = 1'b0;
    tick();
    n_checks++; if (fwd_count !== 16'hFFFF) begin n_fail++; $display("FAIL count_sat: got %h expected ffff", fwd_count); end
  endtask
`endif

  initial begin
    fwd_dummy = '0;
    test_reset();
    test_basic();
    test_forwarding();
    test_override();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef FWD_COUNT_EN
    test_fwd_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
